// File: rtl/int_to_float_if.sv
// Streaming handshake bundle for the integer-to-float converter.
// The master drives input data and downstream ready; the slave is the converter.
interface int_to_float_if #(
    parameter int unsigned IN_WIDTH = 8
);
    logic                in_valid;
    logic                in_ready;
    logic [IN_WIDTH-1:0] in_data;
    logic                out_valid;
    logic                out_ready;
    logic [31:0]         out_float;
    logic                out_inexact;

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_float,
        input  out_inexact
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_float,
        output out_inexact
    );
endinterface

// File: rtl/int_to_float_pipe.sv
// Three-stage integer to IEEE754 single-precision converter with round-to-nearest-even,
// inexact flag and a global-stall valid/ready pipeline.
module int_to_float_pipe #(
    parameter int unsigned IN_WIDTH = 8,
    parameter bit          SIGNED   = 1'b0
) (
    input logic           clk,
    input logic           rst,
    int_to_float_if.slave bus
);
    localparam int unsigned W     = IN_WIDTH;
    localparam int          Wi    = int'(IN_WIDTH);
    localparam bit          Exact = SIGNED ? (W <= 25) : (W <= 24);
    localparam logic [W-1:0] OneW = {{(W-1){1'b0}}, 1'b1};

    logic         enable;

    logic         s1_valid_q, s1_valid_d;
    logic         s1_sign_q, s1_sign_d;
    logic         s1_zero_q, s1_zero_d;
    logic [W-1:0] s1_mag_q, s1_mag_d;

    logic         s2_valid_q, s2_valid_d;
    logic         s2_sign_q, s2_sign_d;
    logic         s2_zero_q, s2_zero_d;
    logic [5:0]   s2_pos_q, s2_pos_d;
    logic [W-1:0] s2_norm_q, s2_norm_d;

    logic         out_valid_q, out_valid_d;
    logic [31:0]  out_float_q, out_float_d;
    logic         out_inexact_q, out_inexact_d;

    logic [5:0]   lod_pos;
    logic [63:0]  norm_ext;
    logic [23:0]  sig;
    logic         guard;
    logic         sticky;
    logic         round_up;
    logic [24:0]  sig_rnd;
    logic [7:0]   exp_biased;
    logic [22:0]  fraction;
    logic [31:0]  packed_float;

    // Single stall signal shared by every stage; bubbles move with the pipe.
    assign enable       = !out_valid_q || bus.out_ready;
    assign bus.in_ready = enable;

    assign bus.out_valid   = out_valid_q;
    assign bus.out_float   = out_float_q;
    assign bus.out_inexact = out_inexact_q;

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_sign_d  = s1_sign_q;
        s1_zero_d  = s1_zero_q;
        s1_mag_d   = s1_mag_q;
        if (enable) begin
            s1_valid_d = bus.in_valid;
            s1_sign_d  = SIGNED ? bus.in_data[W-1] : 1'b0;
            s1_zero_d  = (bus.in_data == '0);
            // W-bit negate: the most negative value maps onto 2^(W-1) unchanged.
            s1_mag_d   = s1_sign_d ? (~bus.in_data + OneW) : bus.in_data;
        end
    end

    always_comb begin
        lod_pos = '0;
        for (int i = 0; i < Wi; i++) begin
            if (s1_mag_q[i]) begin
                lod_pos = 6'(i);
            end
        end
    end

    always_comb begin
        s2_valid_d = s2_valid_q;
        s2_sign_d  = s2_sign_q;
        s2_zero_d  = s2_zero_q;
        s2_pos_d   = s2_pos_q;
        s2_norm_d  = s2_norm_q;
        if (enable) begin
            s2_valid_d = s1_valid_q;
            s2_sign_d  = s1_sign_q;
            s2_zero_d  = s1_zero_q;
            s2_pos_d   = lod_pos;
            s2_norm_d  = s1_mag_q << (6'(W - 1) - lod_pos);
        end
    end

    // Leading one lands at bit 63; narrow inputs leave constant-zero guard/sticky bits.
    always_comb begin
        norm_ext   = {s2_norm_q, {(64 - W){1'b0}}};
        sig        = norm_ext[63:40];
        guard      = Exact ? 1'b0 : norm_ext[39];
        sticky     = Exact ? 1'b0 : |norm_ext[38:0];
        round_up   = guard && (sticky || sig[0]);
        sig_rnd    = {1'b0, sig} + {24'd0, round_up};
        exp_biased = {2'b00, s2_pos_q} + 8'd127 + {7'd0, sig_rnd[24]};
        fraction   = sig_rnd[24] ? sig_rnd[23:1] : sig_rnd[22:0];
        if (s2_zero_q) begin
            packed_float = 32'h0000_0000;
        end else begin
            packed_float = {s2_sign_q, exp_biased, fraction};
        end
    end

    always_comb begin
        out_valid_d   = out_valid_q;
        out_float_d   = out_float_q;
        out_inexact_d = out_inexact_q;
        if (enable) begin
            out_valid_d = s2_valid_q;
            if (s2_valid_q) begin
                out_float_d   = packed_float;
                out_inexact_d = !s2_zero_q && (guard || sticky);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q    <= 1'b0;
            s1_sign_q     <= 1'b0;
            s1_zero_q     <= 1'b0;
            s1_mag_q      <= '0;
            s2_valid_q    <= 1'b0;
            s2_sign_q     <= 1'b0;
            s2_zero_q     <= 1'b0;
            s2_pos_q      <= '0;
            s2_norm_q     <= '0;
            out_valid_q   <= 1'b0;
            out_float_q   <= '0;
            out_inexact_q <= 1'b0;
        end else begin
            s1_valid_q    <= s1_valid_d;
            s1_sign_q     <= s1_sign_d;
            s1_zero_q     <= s1_zero_d;
            s1_mag_q      <= s1_mag_d;
            s2_valid_q    <= s2_valid_d;
            s2_sign_q     <= s2_sign_d;
            s2_zero_q     <= s2_zero_d;
            s2_pos_q      <= s2_pos_d;
            s2_norm_q     <= s2_norm_d;
            out_valid_q   <= out_valid_d;
            out_float_q   <= out_float_d;
            out_inexact_q <= out_inexact_d;
        end
    end
endmodule

// File: tb/tb_int_to_float_pipe.sv
// Directed bench: unsigned/signed 8-bit and 32-bit rounding instances, back-pressure and
// mid-flight reset on the 8-bit unsigned instance.
module tb_int_to_float_pipe;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fails  = 0;

    int_to_float_if #(.IN_WIDTH(8))  u8_if ();
    int_to_float_if #(.IN_WIDTH(8))  s8_if ();
    int_to_float_if #(.IN_WIDTH(32)) u32_if ();

    int_to_float_pipe #(.IN_WIDTH(8), .SIGNED(1'b0)) u_u8 (
        .clk (clk),
        .rst (rst),
        .bus (u8_if)
    );

    int_to_float_pipe #(.IN_WIDTH(8), .SIGNED(1'b1)) u_s8 (
        .clk (clk),
        .rst (rst),
        .bus (s8_if)
    );

    int_to_float_pipe #(.IN_WIDTH(32), .SIGNED(1'b0)) u_u32 (
        .clk (clk),
        .rst (rst),
        .bus (u32_if)
    );

    logic [7:0]  u8_vec  [5] = '{8'd0, 8'd1, 8'd2, 8'd200, 8'd255};
    logic [31:0] u8_exp  [5] = '{32'h0000_0000, 32'h3F80_0000, 32'h4000_0000,
                                 32'h4348_0000, 32'h437F_0000};
    logic [7:0]  s8_vec  [3] = '{8'hFF, 8'h80, 8'h7F};
    logic [31:0] s8_exp  [3] = '{32'hBF80_0000, 32'hC300_0000, 32'h42FE_0000};
    logic [31:0] u32_vec [5] = '{32'd16777217, 32'd16777219, 32'd16777221,
                                 32'hFFFF_FFFF, 32'd16777216};
    logic [31:0] u32_exp [5] = '{32'h4B80_0000, 32'h4B80_0002, 32'h4B80_0002,
                                 32'h4F80_0000, 32'h4B80_0000};
    logic        u32_inx [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [7:0]  bp_vec  [5] = '{8'd10, 8'd20, 8'd30, 8'd40, 8'd50};
    logic [31:0] bp_exp  [5] = '{32'h4120_0000, 32'h41A0_0000, 32'h41F0_0000,
                                 32'h4220_0000, 32'h4248_0000};
    logic [7:0]  rs_vec  [3] = '{8'd1, 8'd2, 8'd3};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    int          sent;
    int          recv;
    logic        stalled_prev;
    logic [31:0] prev_float;

    initial begin
        rst = 1'b1;
        u8_if.in_valid   = 1'b0;
        u8_if.in_data    = '0;
        u8_if.out_ready  = 1'b1;
        s8_if.in_valid   = 1'b0;
        s8_if.in_data    = '0;
        s8_if.out_ready  = 1'b1;
        u32_if.in_valid  = 1'b0;
        u32_if.in_data   = '0;
        u32_if.out_ready = 1'b1;
        step();
        step();
        rst = 1'b0;
        #1;
        chk("rst_out_valid", 32'(u8_if.out_valid), 32'd0);
        chk("rst_out_float", u8_if.out_float, 32'h0);
        chk("rst_out_inexact", 32'(u8_if.out_inexact), 32'd0);
        chk("rst_in_ready", 32'(u8_if.in_ready), 32'd1);

        // Back-to-back streams on all three instances; results start 3 cycles after input.
        for (int k = 0; k < 8; k++) begin
            u8_if.in_valid  = (k < 5);
            s8_if.in_valid  = (k < 3);
            u32_if.in_valid = (k < 5);
            if (k < 5) u8_if.in_data = u8_vec[k];
            if (k < 3) s8_if.in_data = s8_vec[k];
            if (k < 5) u32_if.in_data = u32_vec[k];
            chk("u8_valid", 32'(u8_if.out_valid), 32'(k >= 3));
            chk("s8_valid", 32'(s8_if.out_valid), 32'(k >= 3 && k < 6));
            chk("u32_valid", 32'(u32_if.out_valid), 32'(k >= 3));
            if (k >= 3) begin
                chk("u8_float", u8_if.out_float, u8_exp[k-3]);
                chk("u8_inexact", 32'(u8_if.out_inexact), 32'd0);
                chk("u32_float", u32_if.out_float, u32_exp[k-3]);
                chk("u32_inexact", 32'(u32_if.out_inexact), 32'(u32_inx[k-3]));
            end
            if (k >= 3 && k < 6) begin
                chk("s8_float", s8_if.out_float, s8_exp[k-3]);
                chk("s8_inexact", 32'(s8_if.out_inexact), 32'd0);
            end
            step();
        end
        u8_if.in_valid  = 1'b0;
        s8_if.in_valid  = 1'b0;
        u32_if.in_valid = 1'b0;

        // Back-pressure: downstream stalls for 4 cycles while the source keeps offering.
        sent = 0;
        recv = 0;
        stalled_prev = 1'b0;
        prev_float = '0;
        for (int cyc = 0; cyc < 40 && recv < 5; cyc++) begin
            u8_if.out_ready = !(cyc >= 4 && cyc < 8);
            u8_if.in_valid  = (sent < 5);
            if (sent < 5) u8_if.in_data = bp_vec[sent];
            #1;
            if (u8_if.out_valid && !u8_if.out_ready) begin
                chk("bp_in_ready", 32'(u8_if.in_ready), 32'd0);
                if (stalled_prev) chk("bp_hold", u8_if.out_float, prev_float);
            end
            if (u8_if.out_valid && u8_if.out_ready) begin
                chk("bp_data", u8_if.out_float, bp_exp[recv]);
                recv++;
            end
            if (u8_if.in_valid && u8_if.in_ready) sent++;
            stalled_prev = u8_if.out_valid && !u8_if.out_ready;
            prev_float   = u8_if.out_float;
            step();
        end
        chk("bp_count", 32'(recv), 32'd5);
        u8_if.in_valid  = 1'b0;
        u8_if.out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            chk("bp_drained", 32'(u8_if.out_valid), 32'd0);
            step();
        end

        // Reset with three conversions in flight.
        for (int k = 0; k < 3; k++) begin
            u8_if.in_valid = 1'b1;
            u8_if.in_data  = rs_vec[k];
            step();
        end
        u8_if.in_valid = 1'b0;
        rst = 1'b1;
        chk("rs_before", 32'(u8_if.out_valid), 32'd1);
        step();
        rst = 1'b0;
        #1;
        chk("rs_out_valid", 32'(u8_if.out_valid), 32'd0);
        chk("rs_out_float", u8_if.out_float, 32'h0);
        chk("rs_out_inexact", 32'(u8_if.out_inexact), 32'd0);
        chk("rs_in_ready", 32'(u8_if.in_ready), 32'd1);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("rs_no_stale", 32'(u8_if.out_valid), 32'd0);
        end
        u8_if.in_valid = 1'b1;
        u8_if.in_data  = 8'd200;
        step();
        u8_if.in_valid = 1'b0;
        chk("rs_lat1", 32'(u8_if.out_valid), 32'd0);
        step();
        chk("rs_lat2", 32'(u8_if.out_valid), 32'd0);
        step();
        chk("rs_lat3", 32'(u8_if.out_valid), 32'd1);
        chk("rs_float", u8_if.out_float, 32'h4348_0000);
        step();
        chk("rs_single", 32'(u8_if.out_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
